// File: rtl/uart_cmd_decoder.sv
// Parses A5/CMD/DATA/CHK frames into waveform/freq settings; CHK -> settings 1 cycle, ACK/NAK >= 2 cycles.
// Response held in RESP while tx_busy; bytes arriving in EXEC/RESP are dropped. `CMD_READBACK_EN makes ping return status.
module uart_cmd_decoder #(
    parameter logic [7:0]  SOF_BYTE       = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 260416,
    parameter int unsigned FREQ_MAX       = 9,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic [1:0] waveform_sel,
    output logic [3:0] freq_sel,
    output logic       cfg_update,
    output logic       frame_err
);

    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       FREQ_MAX_B = 8'(FREQ_MAX);
    localparam logic [7:0]       CMD_WAVE   = 8'h01;
    localparam logic [7:0]       CMD_FREQ   = 8'h02;
    localparam logic [7:0]       CMD_PING   = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_DATA,
        ST_GET_CHK,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       chk_q, chk_d;
    logic             tx_en_q, tx_en_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [1:0]       waveform_sel_q, waveform_sel_d;
    logic [3:0]       freq_sel_q, freq_sel_d;
    logic             cfg_update_q, cfg_update_d;
    logic             frame_err_q, frame_err_d;

    // Frame decision, evaluated from the latched bytes while in EXEC.
    logic       chk_ok;
    logic       wave_wr;
    logic       freq_wr;
    logic       exec_err;
    logic [7:0] resp_byte;
    logic [7:0] ping_byte;

`ifdef CMD_READBACK_EN
    assign ping_byte = {2'b00, waveform_sel_q, freq_sel_q};
`else
    assign ping_byte = ACK_BYTE;
`endif

    always_comb begin
        chk_ok    = (chk_q == (cmd_q ^ data_q));
        wave_wr   = 1'b0;
        freq_wr   = 1'b0;
        exec_err  = 1'b0;
        resp_byte = NAK_BYTE;
        if (!chk_ok) begin
            exec_err = 1'b1;
        end else begin
            case (cmd_q)
                CMD_WAVE: begin
                    wave_wr   = 1'b1;
                    resp_byte = ACK_BYTE;
                end
                CMD_FREQ: begin
                    if (data_q <= FREQ_MAX_B) begin
                        freq_wr   = 1'b1;
                        resp_byte = ACK_BYTE;
                    end else begin
                        exec_err  = 1'b1;
                    end
                end
                CMD_PING: resp_byte = ping_byte;
                default:  exec_err  = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cmd_d          = cmd_q;
        data_d         = data_q;
        chk_d          = chk_q;
        tx_en_d        = 1'b0;
        tx_data_d      = tx_data_q;
        waveform_sel_d = waveform_sel_q;
        freq_sel_d     = freq_sel_q;
        cfg_update_d   = 1'b0;
        frame_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SOF_BYTE)) begin
                    state_d = ST_GET_CMD;
                    cnt_d   = '0;
                end
            end
            ST_GET_CMD, ST_GET_DATA, ST_GET_CHK: begin
                // An arriving byte wins over an expiring inter-byte timer.
                if (rx_valid) begin
                    cnt_d = '0;
                    case (state_q)
                        ST_GET_CMD: begin
                            cmd_d   = rx_data;
                            state_d = ST_GET_DATA;
                        end
                        ST_GET_DATA: begin
                            data_d  = rx_data;
                            state_d = ST_GET_CHK;
                        end
                        default: begin
                            chk_d   = rx_data;
                            state_d = ST_EXEC;
                        end
                    endcase
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EXEC: begin
                tx_data_d    = resp_byte;
                frame_err_d  = exec_err;
                cfg_update_d = wave_wr | freq_wr;
                if (wave_wr) begin
                    waveform_sel_d = data_q[1:0];
                end
                if (freq_wr) begin
                    freq_sel_d = data_q[3:0];
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (!tx_busy) begin
                    tx_en_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            cmd_q          <= '0;
            data_q         <= '0;
            chk_q          <= '0;
            tx_en_q        <= 1'b0;
            tx_data_q      <= '0;
            waveform_sel_q <= '0;
            freq_sel_q     <= '0;
            cfg_update_q   <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cmd_q          <= cmd_d;
            data_q         <= data_d;
            chk_q          <= chk_d;
            tx_en_q        <= tx_en_d;
            tx_data_q      <= tx_data_d;
            waveform_sel_q <= waveform_sel_d;
            freq_sel_q     <= freq_sel_d;
            cfg_update_q   <= cfg_update_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign tx_en        = tx_en_q;
    assign tx_data      = tx_data_q;
    assign waveform_sel = waveform_sel_q;
    assign freq_sel     = freq_sel_q;
    assign cfg_update   = cfg_update_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: frame-level reference model compared every cycle, plus literal spot checks.
module tb_uart_cmd_decoder;

    localparam int T = 64;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       tx_busy  = 1'b0;
    logic       tx_en;
    logic [7:0] tx_data;
    logic [1:0] waveform_sel;
    logic [3:0] freq_sel;
    logic       cfg_update;
    logic       frame_err;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_busy     (tx_busy),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .waveform_sel(waveform_sel),
        .freq_sel    (freq_sel),
        .cfg_update  (cfg_update),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         tx_cnt = 0;
    int         cfg_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] last_tx = 8'h00;
    bit         busy_rand = 1'b0;

    // Reference model: bytes collected since SOF, cycles since last byte, pending decision/response.
    logic [7:0] m_frame[$];
    bit         m_in_frame = 0;
    int         m_gap = 0;
    bit         m_decide = 0;
    bit         m_resp = 0;
    logic [7:0] m_tx_data = 8'h00;
    logic [1:0] m_ws = 2'd0;
    logic [3:0] m_fs = 4'd0;
    bit         m_tx_en = 0;
    bit         m_cfg = 0;
    bit         m_err = 0;

    function automatic void model_reset();
        m_frame.delete();
        m_in_frame = 0; m_gap = 0; m_decide = 0; m_resp = 0;
        m_tx_data = 8'h00; m_ws = 2'd0; m_fs = 4'd0;
        m_tx_en = 0; m_cfg = 0; m_err = 0;
    endfunction

    function automatic void model_decide();
        logic [7:0] c = m_frame[1];
        logic [7:0] d = m_frame[2];
        logic [7:0] k = m_frame[3];
        m_tx_data = 8'h15;
        if (k != (c ^ d)) begin
            m_err = 1;
        end else if (c == 8'h01) begin
            m_ws = d[1:0]; m_cfg = 1; m_tx_data = 8'h06;
        end else if (c == 8'h02) begin
            if (d <= 8'd9) begin
                m_fs = d[3:0]; m_cfg = 1; m_tx_data = 8'h06;
            end else begin
                m_err = 1;
            end
        end else if (c == 8'h03) begin
`ifdef CMD_READBACK_EN
            m_tx_data = {2'b00, m_ws, m_fs};
`else
            m_tx_data = 8'h06;
`endif
        end else begin
            m_err = 1;
        end
    endfunction

    function automatic void model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_tx_en = 0; m_cfg = 0; m_err = 0;
        if (m_decide) begin
            model_decide();
            m_decide = 0;
            m_resp = 1;
        end else if (m_resp) begin
            if (!tx_busy) begin
                m_tx_en = 1;
                m_resp = 0;
            end
        end else if (m_in_frame) begin
            if (rx_valid) begin
                m_frame.push_back(rx_data);
                m_gap = 0;
                if (m_frame.size() == 4) begin
                    m_in_frame = 0;
                    m_decide = 1;
                end
            end else if (m_gap == T - 1) begin
                m_in_frame = 0;
                m_err = 1;
            end else begin
                m_gap++;
            end
        end else if (rx_valid && rx_data == 8'hA5) begin
            m_frame.delete();
            m_frame.push_back(rx_data);
            m_in_frame = 1;
            m_gap = 0;
        end
    endfunction

    task automatic compare();
        logic [16:0] act;
        logic [16:0] exp;
        act = {tx_en, tx_data, waveform_sel, freq_sel, cfg_update, frame_err};
        exp = {m_tx_en, m_tx_data, m_ws, m_fs, m_cfg, m_err};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t got{en,dat,ws,fs,cfg,err}=%h want=%h", $time, act, exp);
        end
        if (tx_en === 1'b1) begin
            tx_cnt++;
            last_tx = tx_data;
        end
        if (cfg_update === 1'b1) cfg_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, advance model on the edge, then let inputs change.
    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
        if (busy_rand) tx_busy = ($urandom_range(0, 2) == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    function automatic int rgap(input bit rnd);
        if (!rnd) return 0;
        if ($urandom_range(0, 19) == 0) return T - 2 + $urandom_range(0, 3);
        return $urandom_range(0, 3);
    endfunction

    task automatic frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k, input bit rnd);
        send(8'hA5); idle(rgap(rnd));
        send(c);     idle(rgap(rnd));
        send(d);     idle(rgap(rnd));
        send(k);
    endtask

    initial begin
        int e0;
        int t0;
        logic [7:0] c;
        logic [7:0] d;

        idle(3);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_wave", waveform_sel, 0);
        chk("reset_freq", freq_sel, 0);
        rst_n = 1'b1;
        idle(2);

        frame(8'h01, 8'h02, 8'h03, 0); idle(6);
        chk("wave_set", waveform_sel, 2);
        chk("wave_cfg_pulses", cfg_cnt, 1);
        chk("wave_tx_count", tx_cnt, 1);
        chk("wave_ack", last_tx, 8'h06);

        frame(8'h02, 8'h05, 8'h07, 0); idle(6);
        chk("freq_set", freq_sel, 5);
        chk("freq_ack", last_tx, 8'h06);

        e0 = err_cnt;
        frame(8'h02, 8'h0C, 8'h0E, 0); idle(6);
        chk("freq_range_nak", last_tx, 8'h15);
        chk("freq_range_err", err_cnt, e0 + 1);
        chk("freq_kept", freq_sel, 5);
        chk("cfg_pulses_total", cfg_cnt, 2);

        frame(8'h01, 8'h01, 8'hFF, 0); idle(6);
        chk("badchk_nak", last_tx, 8'h15);
        chk("badchk_wave_kept", waveform_sel, 2);
        chk("badchk_err", err_cnt, e0 + 2);

        t0 = tx_cnt;
        send(8'hA5); send(8'h01); idle(T + 5);
        chk("timeout_err", err_cnt, e0 + 3);
        chk("timeout_no_tx", tx_cnt, t0);
        frame(8'h01, 8'h03, 8'h02, 0); idle(6);
        chk("after_timeout_wave", waveform_sel, 3);
        chk("after_timeout_tx", tx_cnt, t0 + 1);

        // Longest tolerated gap between bytes still completes the frame.
        e0 = err_cnt;
        send(8'hA5); idle(T - 1); send(8'h01); idle(T - 1);
        send(8'h01); idle(T - 1); send(8'h00); idle(6);
        chk("max_gap_wave", waveform_sel, 1);
        chk("max_gap_no_err", err_cnt, e0);

        frame(8'h01, 8'h03, 8'h02, 0); idle(6);
        frame(8'h02, 8'h04, 8'h06, 0); idle(6);
        frame(8'h03, 8'h00, 8'h03, 0); idle(6);
`ifdef CMD_READBACK_EN
        chk("ping_resp", last_tx, 8'h34);
`else
        chk("ping_resp", last_tx, 8'h06);
`endif

        tx_busy = 1'b1;
        t0 = tx_cnt;
        frame(8'h01, 8'h00, 8'h01, 0);
        send(8'hA5); send(8'h01); send(8'h01); send(8'h00);
        idle(1000);
        chk("busy_hold", tx_cnt, t0);
        tx_busy = 1'b0;
        idle(6);
        chk("busy_release_tx", tx_cnt, t0 + 1);
        chk("busy_release_ack", last_tx, 8'h06);
        chk("busy_dropped_frame", waveform_sel, 0);

        t0 = tx_cnt;
        send(8'hA5); send(8'h02);
        rst_n = 1'b0;
        model_reset();
        idle(2);
        chk("midframe_reset_freq", freq_sel, 0);
        rst_n = 1'b1;
        idle(6);
        chk("midframe_reset_no_tx", tx_cnt, t0);

        busy_rand = 1'b1;
        for (int i = 0; i < 250; i++) begin
            d = 8'($urandom);
            case ($urandom_range(0, 6))
                0: frame(8'h01, d, 8'h01 ^ d, 1);
                1: begin
                    d = 8'($urandom_range(0, 15));
                    frame(8'h02, d, 8'h02 ^ d, 1);
                end
                2: frame(8'h03, d, 8'h03 ^ d, 1);
                3: begin
                    c = 8'($urandom_range(1, 3));
                    frame(c, d, c ^ d ^ 8'($urandom_range(1, 255)), 1);
                end
                4: begin
                    c = 8'($urandom);
                    frame(c, d, c ^ d, 1);
                end
                5: for (int j = 0; j < 3; j++) send(8'($urandom));
                default: begin
                    send(8'hA5); send(8'($urandom_range(1, 3)));
                    idle(T + $urandom_range(0, 3));
                end
            endcase
            idle($urandom_range(0, 12));
        end
        busy_rand = 1'b0;
        tx_busy = 1'b0;
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
